if_id_fetch_stage: RTL and testbench

- Instruction fetch stage plus IF/ID pipeline register for the LEGv8 datapath.
- Holds the PC and issues requests to instruction memory over a req/ack handshake.
- Buffers returned words into IF/ID and presents opcode = instr[31:21] directly to the main decoder (control_unit) in ID.
- Handles ID-stage stalls through a one-entry skid buffer, and CBZ/B redirects with flush of wrong-path fetches.

---
 rtl/if_id_fetch_stage.sv | 100 ++++++++++
 tb/tb_if_id_fetch_stage.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/if_id_fetch_stage.sv
// if_id_fetch_stage: LEGv8 instruction fetch with req/ack memory handshake, IF/ID register, skid buffer and redirect drain.
module if_id_fetch_stage #(
  parameter int ADDR_W = 64,
  parameter int INSTR_W = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               br_taken,
  input  logic [ADDR_W-1:0]  br_target,
  input  logic               id_stall,
  output logic               if_id_valid,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [ADDR_W-1:0]  if_id_pc,
  output logic [10:0]        opcode
);
  typedef enum logic [1:0] {IDLE, FETCH, HOLD, DRAIN} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, drain_addr_q, drain_addr_d, if_id_pc_q, if_id_pc_d, skid_pc_q, skid_pc_d;
  logic [INSTR_W-1:0] if_id_instr_q, if_id_instr_d, skid_instr_q, skid_instr_d;
  logic if_id_valid_q, if_id_valid_d, skid_valid_q, skid_valid_d;
  logic free;
  assign imem_req = state_q == FETCH || state_q == DRAIN;
  // DRAIN keeps presenting the abandoned address while pc already holds the redirect target
  assign imem_addr = state_q == DRAIN ? drain_addr_q : pc_q;
  assign if_id_valid = if_id_valid_q;
  assign if_id_instr = if_id_instr_q;
  assign if_id_pc = if_id_pc_q;
  assign opcode = if_id_instr_q[31:21];
  assign free = !if_id_valid_q || !id_stall;
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    drain_addr_d = drain_addr_q;
    if_id_valid_d = if_id_valid_q && id_stall;
    if_id_instr_d = if_id_instr_q;
    if_id_pc_d = if_id_pc_q;
    skid_valid_d = skid_valid_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d = skid_pc_q;
    if (state_q == IDLE) begin
      state_d = FETCH;
    end else if (br_taken) begin
      pc_d = br_target & ~ADDR_W'(3);
      if_id_valid_d = 1'b0;
      skid_valid_d = 1'b0;
      state_d = imem_req && !imem_ack ? DRAIN : FETCH;
      drain_addr_d = imem_addr;
    end else if (state_q == FETCH && imem_ack) begin
      pc_d = pc_q + ADDR_W'(4);
      if (free) begin
        if_id_valid_d = 1'b1;
        if_id_instr_d = imem_rdata;
        if_id_pc_d = pc_q;
      end else begin
        skid_valid_d = 1'b1;
        skid_instr_d = imem_rdata;
        skid_pc_d = pc_q;
        state_d = HOLD;
      end
    end else if (state_q == HOLD && !id_stall) begin
      if_id_valid_d = 1'b1;
      if_id_instr_d = skid_instr_q;
      if_id_pc_d = skid_pc_q;
      skid_valid_d = 1'b0;
      skid_instr_d = '0;
      skid_pc_d = '0;
      state_d = FETCH;
    end else if (state_q == DRAIN && imem_ack) begin
      state_d = FETCH;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q <= RESET_PC & ~ADDR_W'(3);
      drain_addr_q <= '0;
      if_id_valid_q <= 1'b0;
      if_id_instr_q <= '0;
      if_id_pc_q <= '0;
      skid_valid_q <= 1'b0;
      skid_instr_q <= '0;
      skid_pc_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      drain_addr_q <= drain_addr_d;
      if_id_valid_q <= if_id_valid_d;
      if_id_instr_q <= if_id_instr_d;
      if_id_pc_q <= if_id_pc_d;
      skid_valid_q <= skid_valid_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q <= skid_pc_d;
    end
  end
endmodule

// File: tb/tb_if_id_fetch_stage.sv
// tb_if_id_fetch_stage: scoreboard bench for the fetch stage; a second instance covers PC wrap-around.
module tb_if_id_fetch_stage;
  logic clk = 1'b0;
  logic reset, imem_ack, br_taken, id_stall;
  logic [31:0] imem_rdata;
  logic [63:0] br_target;
  logic imem_req, if_id_valid, w_req, w_valid;
  logic [63:0] imem_addr, if_id_pc, w_addr, w_pc;
  logic [31:0] if_id_instr, w_instr;
  logic [10:0] opcode, w_opcode;
  typedef struct packed {logic [31:0] instr; logic [63:0] pc;} ent_t;
  typedef struct {logic ack; logic stall; logic br; logic [63:0] tgt; logic req; logic [63:0] addr; logic push;} row_t;
  ent_t exp_q[$];
  int total = 0, bad = 0, seq = 0;

  if_id_fetch_stage dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .br_taken(br_taken), .br_target(br_target), .id_stall(id_stall),
    .if_id_valid(if_id_valid), .if_id_instr(if_id_instr), .if_id_pc(if_id_pc), .opcode(opcode)
  );
  if_id_fetch_stage #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) dut_w (
    .clk(clk), .reset(reset), .imem_req(w_req), .imem_addr(w_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .br_taken(br_taken), .br_target(br_target), .id_stall(id_stall),
    .if_id_valid(w_valid), .if_id_instr(w_instr), .if_id_pc(w_pc), .opcode(w_opcode)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    reset = 1'b1;
    #2;
    total++;
    if ({imem_req, if_id_valid} !== 2'b00) begin bad++; $display("FAIL reset_ctrl: req/valid=%b%b want 00", imem_req, if_id_valid); end
    total++;
    if ({if_id_instr, if_id_pc, opcode} !== '0) begin bad++; $display("FAIL reset_data: instr=%h pc=%h opcode=%h want 0", if_id_instr, if_id_pc, opcode); end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    total++;
    if (imem_req !== 1'b0) begin bad++; $display("FAIL reset_idle: req=%b want 0", imem_req); end
    @(posedge clk); #1;
  endtask

  task automatic test_stream();
    row_t t[$];
    for (int k = 0; k < 6; k++) t.push_back('{1, 0, 0, 0, 1, 64'(4 * k), 1});
    t.push_back('{0, 0, 0, 0, 1, 64'h18, 0});
    t.push_back('{0, 0, 0, 0, 1, 64'h18, 0});
    foreach (t[i]) begin
      imem_ack = t[i].ack; id_stall = t[i].stall; br_taken = t[i].br; br_target = t[i].tgt;
      imem_rdata = {11'h458, 21'(seq)}; seq++;
      @(negedge clk);
      total++;
      if (imem_req !== t[i].req || (t[i].req && imem_addr !== t[i].addr)) begin bad++; $display("FAIL stream_addr row %0d: req=%b addr=%h want req=%b addr=%h", i, imem_req, imem_addr, t[i].req, t[i].addr); end
      total++;
      if (if_id_valid !== (exp_q.size() != 0)) begin bad++; $display("FAIL stream_valid row %0d: valid=%b want %b", i, if_id_valid, exp_q.size() != 0); end
      else if (if_id_valid) begin
        total++;
        if ({if_id_instr, if_id_pc, opcode} !== {exp_q[0].instr, exp_q[0].pc, exp_q[0].instr[31:21]}) begin bad++; $display("FAIL stream_word row %0d: instr=%h pc=%h op=%h want instr=%h pc=%h", i, if_id_instr, if_id_pc, opcode, exp_q[0].instr, exp_q[0].pc); end
        if (!id_stall) void'(exp_q.pop_front());
      end
      if (t[i].br) exp_q.delete();
      if (t[i].push) exp_q.push_back('{imem_rdata, t[i].addr});
      @(posedge clk); #1;
    end
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL stream_left: %0d words pending want 0", exp_q.size()); end
  endtask

  task automatic test_stall();
    row_t t[$];
    t.push_back('{1, 0, 0, 0, 1, 64'h18, 1});
    t.push_back('{1, 1, 0, 0, 1, 64'h1C, 1});
    t.push_back('{1, 1, 0, 0, 0, 0, 0});
    t.push_back('{1, 1, 0, 0, 0, 0, 0});
    t.push_back('{0, 0, 0, 0, 0, 0, 0});
    t.push_back('{1, 0, 0, 0, 1, 64'h20, 1});
    t.push_back('{0, 0, 0, 0, 1, 64'h24, 0});
    t.push_back('{0, 0, 0, 0, 1, 64'h24, 0});
    foreach (t[i]) begin
      imem_ack = t[i].ack; id_stall = t[i].stall; br_taken = t[i].br; br_target = t[i].tgt;
      imem_rdata = {11'h458, 21'(seq)}; seq++;
      @(negedge clk);
      total++;
      if (imem_req !== t[i].req || (t[i].req && imem_addr !== t[i].addr)) begin bad++; $display("FAIL stall_addr row %0d: req=%b addr=%h want req=%b addr=%h", i, imem_req, imem_addr, t[i].req, t[i].addr); end
      total++;
      if (if_id_valid !== (exp_q.size() != 0)) begin bad++; $display("FAIL stall_valid row %0d: valid=%b want %b", i, if_id_valid, exp_q.size() != 0); end
      else if (if_id_valid) begin
        total++;
        if ({if_id_instr, if_id_pc, opcode} !== {exp_q[0].instr, exp_q[0].pc, exp_q[0].instr[31:21]}) begin bad++; $display("FAIL stall_word row %0d: instr=%h pc=%h op=%h want instr=%h pc=%h", i, if_id_instr, if_id_pc, opcode, exp_q[0].instr, exp_q[0].pc); end
        if (!id_stall) void'(exp_q.pop_front());
      end
      if (t[i].br) exp_q.delete();
      if (t[i].push) exp_q.push_back('{imem_rdata, t[i].addr});
      @(posedge clk); #1;
    end
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL stall_left: %0d words pending want 0", exp_q.size()); end
  endtask

  task automatic test_redirect();
    row_t t[$];
    t.push_back('{1, 0, 1, 64'h10, 1, 64'h24, 0});
    t.push_back('{0, 0, 1, 64'h41, 1, 64'h10, 0});
    t.push_back('{0, 0, 0, 0, 1, 64'h10, 0});
    t.push_back('{0, 0, 1, 64'h80, 1, 64'h10, 0});
    t.push_back('{1, 0, 1, 64'h41, 1, 64'h10, 0});
    t.push_back('{0, 0, 0, 0, 1, 64'h40, 0});
    t.push_back('{1, 0, 0, 0, 1, 64'h40, 1});
    t.push_back('{0, 0, 0, 0, 1, 64'h44, 0});
    t.push_back('{0, 0, 0, 0, 1, 64'h44, 0});
    foreach (t[i]) begin
      imem_ack = t[i].ack; id_stall = t[i].stall; br_taken = t[i].br; br_target = t[i].tgt;
      imem_rdata = {11'h458, 21'(seq)}; seq++;
      @(negedge clk);
      total++;
      if (imem_req !== t[i].req || (t[i].req && imem_addr !== t[i].addr)) begin bad++; $display("FAIL redirect_addr row %0d: req=%b addr=%h want req=%b addr=%h", i, imem_req, imem_addr, t[i].req, t[i].addr); end
      total++;
      if (if_id_valid !== (exp_q.size() != 0)) begin bad++; $display("FAIL redirect_valid row %0d: valid=%b want %b", i, if_id_valid, exp_q.size() != 0); end
      else if (if_id_valid) begin
        total++;
        if ({if_id_instr, if_id_pc, opcode} !== {exp_q[0].instr, exp_q[0].pc, exp_q[0].instr[31:21]}) begin bad++; $display("FAIL redirect_word row %0d: instr=%h pc=%h op=%h want instr=%h pc=%h", i, if_id_instr, if_id_pc, opcode, exp_q[0].instr, exp_q[0].pc); end
        if (!id_stall) void'(exp_q.pop_front());
      end
      if (t[i].br) exp_q.delete();
      if (t[i].push) exp_q.push_back('{imem_rdata, t[i].addr});
      @(posedge clk); #1;
    end
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL redirect_left: %0d words pending want 0", exp_q.size()); end
  endtask

  task automatic test_flush();
    row_t t[$];
    t.push_back('{1, 0, 0, 0, 1, 64'h44, 1});
    t.push_back('{1, 1, 1, 64'h100, 1, 64'h48, 0});
    t.push_back('{0, 1, 0, 0, 1, 64'h100, 0});
    t.push_back('{1, 0, 0, 0, 1, 64'h100, 1});
    t.push_back('{0, 0, 0, 0, 1, 64'h104, 0});
    t.push_back('{0, 0, 0, 0, 1, 64'h104, 0});
    t.push_back('{1, 0, 0, 0, 1, 64'h104, 1});
    t.push_back('{1, 1, 0, 0, 1, 64'h108, 1});
    t.push_back('{0, 1, 1, 64'h200, 0, 0, 0});
    t.push_back('{0, 0, 0, 0, 1, 64'h200, 0});
    foreach (t[i]) begin
      imem_ack = t[i].ack; id_stall = t[i].stall; br_taken = t[i].br; br_target = t[i].tgt;
      imem_rdata = {11'h458, 21'(seq)}; seq++;
      @(negedge clk);
      total++;
      if (imem_req !== t[i].req || (t[i].req && imem_addr !== t[i].addr)) begin bad++; $display("FAIL flush_addr row %0d: req=%b addr=%h want req=%b addr=%h", i, imem_req, imem_addr, t[i].req, t[i].addr); end
      total++;
      if (if_id_valid !== (exp_q.size() != 0)) begin bad++; $display("FAIL flush_valid row %0d: valid=%b want %b", i, if_id_valid, exp_q.size() != 0); end
      else if (if_id_valid) begin
        total++;
        if ({if_id_instr, if_id_pc, opcode} !== {exp_q[0].instr, exp_q[0].pc, exp_q[0].instr[31:21]}) begin bad++; $display("FAIL flush_word row %0d: instr=%h pc=%h op=%h want instr=%h pc=%h", i, if_id_instr, if_id_pc, opcode, exp_q[0].instr, exp_q[0].pc); end
        if (!id_stall) void'(exp_q.pop_front());
      end
      if (t[i].br) exp_q.delete();
      if (t[i].push) exp_q.push_back('{imem_rdata, t[i].addr});
      @(posedge clk); #1;
    end
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL flush_left: %0d words pending want 0", exp_q.size()); end
  endtask

  task automatic test_wrap();
    imem_ack = 1'b0; id_stall = 1'b0; br_taken = 1'b0;
    reset = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    total++;
    if (w_req !== 1'b0) begin bad++; $display("FAIL wrap_idle: req=%b want 0", w_req); end
    @(posedge clk); #1;
    imem_ack = 1'b1;
    imem_rdata = 32'h8B02_0020;
    @(negedge clk);
    total++;
    if (w_req !== 1'b1 || w_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin bad++; $display("FAIL wrap_first: req=%b addr=%h want 1/fffffffffffffffc", w_req, w_addr); end
    @(posedge clk); #1;
    @(negedge clk);
    total++;
    if (w_addr !== 64'h0) begin bad++; $display("FAIL wrap_second: addr=%h want 0", w_addr); end
    total++;
    if (w_valid !== 1'b1 || w_pc !== 64'hFFFF_FFFF_FFFF_FFFC || w_opcode !== 11'b10001011000) begin bad++; $display("FAIL wrap_ifid: valid=%b pc=%h op=%b want 1/fffffffffffffffc/10001011000", w_valid, w_pc, w_opcode); end
    @(posedge clk); #1;
    imem_ack = 1'b0;
  endtask

  task automatic test_reset_drain();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    imem_ack = 1'b1; imem_rdata = 32'h8B02_0021;
    @(posedge clk); #1;
    imem_rdata = 32'h8B02_0022;
    @(posedge clk); #1;
    imem_ack = 1'b0; br_taken = 1'b1; br_target = 64'h200;
    @(posedge clk); #1;
    br_taken = 1'b0;
    @(negedge clk);
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 64'h8) begin bad++; $display("FAIL rdrain_pending: req=%b addr=%h want 1/8", imem_req, imem_addr); end
    #1 reset = 1'b1;
    #1;
    total++;
    if ({imem_req, if_id_valid} !== 2'b00 || imem_addr !== 64'h0) begin bad++; $display("FAIL rdrain_async_ctrl: req=%b valid=%b addr=%h want 0/0/0", imem_req, if_id_valid, imem_addr); end
    total++;
    if ({if_id_instr, if_id_pc, opcode} !== '0) begin bad++; $display("FAIL rdrain_async_data: instr=%h pc=%h op=%h want 0", if_id_instr, if_id_pc, opcode); end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    total++;
    if (imem_req !== 1'b0) begin bad++; $display("FAIL rdrain_idle: req=%b want 0", imem_req); end
    @(posedge clk); #1;
    @(negedge clk);
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 64'h0) begin bad++; $display("FAIL rdrain_refetch: req=%b addr=%h want 1/0", imem_req, imem_addr); end
  endtask

  initial begin
    reset = 1'b1; imem_ack = 1'b0; br_taken = 1'b0; id_stall = 1'b0; br_target = '0; imem_rdata = '0;
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_flush();
    test_wrap();
    test_reset_drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
